// File: rtl/pulse_filter_mc.sv
// rtl/pulse_filter_mc.sv - multi-channel programmable debounce filter with registered rise/fall strobes
// Optional sticky glitch flags: define PULSE_FILT_GLITCH_EN.
module pulse_filter_mc #(
  parameter int CH          = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] filt_len,
  input  logic [CH-1:0]    pulse_in,
`ifdef PULSE_FILT_GLITCH_EN
  input  logic [CH-1:0]    glitch_clr,
  output logic [CH-1:0]    glitch_flag,
`endif
  output logic [CH-1:0]    level_out,
  output logic [CH-1:0]    rise_pulse,
  output logic [CH-1:0]    fall_pulse
);

  localparam logic [CNT_W:0]   THR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CH-1:0]    sync_q [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_q  [CH];
  logic [CH-1:0]    s;
  logic [CNT_W:0]   thr;
  logic [CH-1:0]    hit;

  assign s = sync_q[SYNC_STAGES-1];

  // Compare one bit wider than the counter so cnt+1 can never wrap past thr.
  always_comb begin
    hit = '0;
    thr = (filt_len == '0) ? THR_ONE : {1'b0, filt_len};
    for (int i = 0; i < CH; i++) begin
      hit[i] = ({1'b0, cnt_q[i]} + THR_ONE) >= thr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      for (int i = 0; i < CH; i++) cnt_q[i] <= '0;
      level_out  <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
    end else begin
      sync_q[0] <= pulse_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      for (int i = 0; i < CH; i++) begin
        rise_pulse[i] <= 1'b0;
        fall_pulse[i] <= 1'b0;
        if (s[i] == level_out[i]) begin
          cnt_q[i] <= '0;
        end else if (hit[i]) begin
          level_out[i]  <= s[i];
          cnt_q[i]      <= '0;
          rise_pulse[i] <= s[i];
          fall_pulse[i] <= ~s[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

`ifdef PULSE_FILT_GLITCH_EN
  // A run that returns to the current level before confirming is a glitch; set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_flag <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if ((s[i] == level_out[i]) && (cnt_q[i] != '0)) glitch_flag[i] <= 1'b1;
        else if (glitch_clr[i])                         glitch_flag[i] <= 1'b0;
      end
    end
  end
`endif

endmodule
